// File: rtl/spi_slave_pkg.sv
// Shared command codes, FSM states and MISO load selectors for the SPI slave.
package spi_slave_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h02;
    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] CMD_ARM_RESET  = 8'h66;
    localparam logic [7:0] CMD_FIRE_RESET = 8'h99;
    localparam logic [7:0] CMD_PD         = 8'hB9;
    localparam logic [7:0] CMD_EXIT_PD    = 8'hAB;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_WDATA, ST_RDATA, ST_DRAIN
    } state_t;

    // What the next SCK fall puts on MISO: keep shifting, or load a fresh byte/word.
    typedef enum logic [1:0] {LD_SHIFT, LD_ZERO, LD_STATUS, LD_WORD} load_t;

endpackage

// File: rtl/spi_slave_sync_if.sv
// Parallel register/memory bus driven by the SPI slave (master side) and served by the fabric.
interface spi_slave_sync_if #(
    parameter int AW = 24,
    parameter int DW = 8
);
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    modport master (output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
                    input  rd_valid, rd_data);
    modport slave  (input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
                    output rd_valid, rd_data);
endinterface

// File: rtl/spi_slave_sync_pin_sync.sv
// Synchronises the raw SPI pins into clk and derives sck/ssn edge pulses.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ssn,
    input  logic sck,
    input  logic mosi,
    output logic ssn_s,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic ssn_fall,
    output logic ssn_rise
);
    logic [SYNC_STAGES-1:0] ssn_pipe, sck_pipe, mosi_pipe;
    logic                   ssn_q, sck_q;

    // ssn chain resets to the inactive (high) level so reset never looks like a select.
    always_ff @(posedge clk) begin
        if (rst) begin
            ssn_pipe  <= '1;
            sck_pipe  <= '0;
            mosi_pipe <= '0;
            ssn_q     <= 1'b1;
            sck_q     <= 1'b0;
        end else begin
            ssn_pipe  <= {ssn_pipe[SYNC_STAGES-2:0], ssn};
            sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], sck};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
            ssn_q     <= ssn_pipe[SYNC_STAGES-1];
            sck_q     <= sck_pipe[SYNC_STAGES-1];
        end
    end

    assign ssn_s    = ssn_pipe[SYNC_STAGES-1];
    assign mosi_s   = mosi_pipe[SYNC_STAGES-1];
    assign sck_rise =  sck_pipe[SYNC_STAGES-1] & ~sck_q;
    assign sck_fall = ~sck_pipe[SYNC_STAGES-1] &  sck_q;
    assign ssn_fall = ~ssn_pipe[SYNC_STAGES-1] &  ssn_q;
    assign ssn_rise =  ssn_pipe[SYNC_STAGES-1] & ~ssn_q;
endmodule

// File: rtl/spi_slave_sync.sv
// Oversampled SPI mode-0 slave bridging CMD/ADDR/DUMMY/DATA frames onto a register bus.
// Optional power-down commands are compiled in with SPI_POWERDOWN_EN.
module spi_slave_sync
    import spi_slave_pkg::*;
#(
    parameter int ADDR_BYTES  = 3,
    parameter int DATA_BYTES  = 1,
    parameter int DUMMY_BYTES = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ssn,
    input  logic                    sck,
    input  logic                    mosi,
    output logic                    miso,
    output logic                    miso_oe,
    spi_slave_sync_if.master        bus,
    input  logic [7:0]              spi_id,
    input  logic [7:0]              spi_status,
    output logic                    reset_out,
    output logic                    pd_out,
    output logic                    busy,
    output logic                    err_underrun
);
    localparam int AW = 8*ADDR_BYTES;
    localparam int DW = 8*DATA_BYTES;
`ifdef SPI_POWERDOWN_EN
    localparam bit PD_EN = 1'b1;
`else
    localparam bit PD_EN = 1'b0;
`endif

    logic ssn_s, mosi_s, sck_rise, sck_fall, ssn_fall, ssn_rise;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk(clk), .rst(rst), .ssn(ssn), .sck(sck), .mosi(mosi),
        .ssn_s(ssn_s), .mosi_s(mosi_s), .sck_rise(sck_rise), .sck_fall(sck_fall),
        .ssn_fall(ssn_fall), .ssn_rise(ssn_rise)
    );

    state_t        state;
    load_t         nxt_load;
    logic [2:0]    bit_cnt, byte_cnt;
    logic [6:0]    shift_in;
    logic          is_read, rd_pending, shadow_vld, reset_armed, powerdown;
    logic [AW-1:0] addr;
    logic [DW-1:0] wacc, shadow, tx_sr;

    logic [7:0]    byte_in;
    logic [AW+7:0] addr_cat;
    logic [DW+7:0] wacc_cat;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] wacc_nxt;

    assign byte_in  = {shift_in, mosi_s};
    assign addr_cat = {addr, byte_in};
    assign wacc_cat = {wacc, byte_in};
    assign addr_nxt = addr_cat[AW-1:0];
    assign wacc_nxt = wacc_cat[DW-1:0];
    assign miso     = tx_sr[DW-1];
    assign pd_out   = powerdown;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE; nxt_load <= LD_SHIFT; bit_cnt <= '0; byte_cnt <= '0;
            shift_in <= '0; is_read <= 1'b0; rd_pending <= 1'b0; shadow_vld <= 1'b0;
            reset_armed <= 1'b0; powerdown <= 1'b0; addr <= '0; wacc <= '0;
            shadow <= '0; tx_sr <= '0; miso_oe <= 1'b0; busy <= 1'b0;
            reset_out <= 1'b0; err_underrun <= 1'b0;
            bus.wr_valid <= 1'b0; bus.wr_addr <= '0; bus.wr_data <= '0;
            bus.rd_req <= 1'b0; bus.rd_addr <= '0;
        end else begin
            bus.wr_valid <= 1'b0;
            bus.rd_req   <= 1'b0;
            reset_out    <= 1'b0;
            busy         <= ~ssn_s;
            miso_oe      <= ~ssn_s;
            if (rd_pending && bus.rd_valid) begin
                shadow     <= bus.rd_data;
                shadow_vld <= 1'b1;
                rd_pending <= 1'b0;
            end
            if (ssn_rise) begin
                state <= ST_IDLE; nxt_load <= LD_SHIFT; tx_sr <= '0;
                rd_pending <= 1'b0; shadow_vld <= 1'b0;
            end else if (ssn_fall) begin
                state <= ST_CMD; nxt_load <= LD_SHIFT; bit_cnt <= '0; byte_cnt <= '0;
                tx_sr <= '0;
                tx_sr[DW-1 -: 8] <= spi_id;
            end else if (state != ST_IDLE) begin
                if (sck_rise) begin
                    shift_in <= byte_in[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        nxt_load <= LD_ZERO;
                        case (state)
                            ST_CMD: begin
                                nxt_load    <= LD_STATUS;
                                state       <= ST_DRAIN;
                                reset_armed <= 1'b0;
                                // While powered down everything but EXIT_PD falls through as unknown.
                                case (byte_in)
                                    CMD_WRITE, CMD_READ: if (!powerdown) begin
                                        state        <= ST_ADDR;
                                        is_read      <= (byte_in == CMD_READ);
                                        err_underrun <= 1'b0;
                                    end
                                    CMD_ARM_RESET:  if (!powerdown) reset_armed <= 1'b1;
                                    CMD_FIRE_RESET: if (!powerdown && reset_armed) reset_out <= 1'b1;
                                    CMD_PD:         if (PD_EN) powerdown <= 1'b1;
                                    CMD_EXIT_PD:    if (PD_EN) powerdown <= 1'b0;
                                    default: ;
                                endcase
                            end
                            ST_ADDR: begin
                                addr     <= addr_nxt;
                                byte_cnt <= byte_cnt + 3'd1;
                                if (byte_cnt == 3'(ADDR_BYTES-1)) begin
                                    byte_cnt <= '0;
                                    if (!is_read) begin
                                        state <= ST_WDATA;
                                    end else begin
                                        bus.rd_req  <= 1'b1;
                                        bus.rd_addr <= addr_nxt;
                                        rd_pending  <= 1'b1;
                                        if (DUMMY_BYTES > 0) begin
                                            state <= ST_DUMMY;
                                        end else begin
                                            state    <= ST_RDATA;
                                            nxt_load <= LD_WORD;
                                        end
                                    end
                                end
                            end
                            ST_DUMMY: begin
                                byte_cnt <= byte_cnt + 3'd1;
                                if (byte_cnt == 3'(DUMMY_BYTES-1)) begin
                                    byte_cnt <= '0;
                                    state    <= ST_RDATA;
                                    nxt_load <= LD_WORD;
                                end
                            end
                            ST_WDATA: begin
                                wacc     <= wacc_nxt;
                                byte_cnt <= byte_cnt + 3'd1;
                                if (byte_cnt == 3'(DATA_BYTES-1)) begin
                                    byte_cnt     <= '0;
                                    bus.wr_valid <= 1'b1;
                                    bus.wr_addr  <= addr;
                                    bus.wr_data  <= wacc_nxt;
                                    addr         <= addr + 1'b1;
                                end
                            end
                            ST_RDATA: begin
                                if (byte_cnt == 3'(DATA_BYTES-1)) begin
                                    byte_cnt <= '0;
                                    nxt_load <= LD_WORD;
                                end else begin
                                    byte_cnt <= byte_cnt + 3'd1;
                                    nxt_load <= LD_SHIFT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                if (sck_fall) begin
                    if (nxt_load == LD_SHIFT) begin
                        tx_sr <= {tx_sr[DW-2:0], 1'b0};
                    end else begin
                        nxt_load <= LD_SHIFT;
                        tx_sr    <= '0;
                        case (nxt_load)
                            LD_STATUS: tx_sr[DW-1 -: 8] <= spi_status;
                            LD_WORD: begin
                                // Word boundary: take prefetched data (or same-cycle return), else underrun.
                                shadow_vld <= 1'b0;
                                if (shadow_vld)                      tx_sr <= shadow;
                                else if (rd_pending && bus.rd_valid) tx_sr <= bus.rd_data;
                                else begin
                                    tx_sr        <= '1;
                                    err_underrun <= 1'b1;
                                end
                                if (!rd_pending || bus.rd_valid) begin
                                    bus.rd_req  <= 1'b1;
                                    bus.rd_addr <= bus.rd_addr + 1'b1;
                                    rd_pending  <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end
endmodule
